fulladder_checker: RTL and testbench

Self-checking response monitor for the full adder. It is the receiving end of the stimulus that drives the adder's `a`/`b`/`c` inputs. The stimulus side strobes each new input vector. After a programmable settle delay, the checker samples the adder's `sum`/`carry`, compares them against the golden full-adder equations and keeps running counters. It also records truth-table coverage and the first failing vector, so adder benches can run self-checking with a single pass/fail readout.

---
 rtl/fulladder_checker.sv | 142 ++++++++++++++
 tb/tb_fulladder_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fulladder_checker.sv
// fulladder_checker: response monitor for a 1-bit full adder.
// Latches {a,b,c} on vec_valid, waits SETTLE cycles, then samples the live
// sum/carry once and scores them against the golden equations. Keeps
// saturating pass/fail counters, truth-table coverage and the first failure.
module fulladder_checker #(
  parameter int SETTLE = 2,   // 0..15
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       coverage,
  output logic             all_covered,
  output logic [4:0]       first_fail
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SETTLE, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] vec;        // latched {a,b,c}
  logic [3:0] scnt;       // settle countdown
  logic       ld_vec;     // capture a new vector and reload the countdown
  logic       do_cmp;     // score live sum/carry this cycle
  logic       clr;        // wipe results for a new run
  logic       exp_sum, exp_carry, cmp_ok;

  assign exp_sum   = vec[2] ^ vec[1] ^ vec[0];
  assign exp_carry = (vec[2] & vec[1]) | (vec[1] & vec[0]) | (vec[2] & vec[0]);
  assign cmp_ok    = (sum == exp_sum) && (carry == exp_carry);

  assign busy        = (state == S_ARMED) || (state == S_SETTLE);
  assign done        = (state == S_DONE);
  assign all_covered = &coverage;

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  // Next state and per-cycle actions; start beats stop beats vector activity
  always_comb begin
    state_nxt = state;
    ld_vec    = 1'b0;
    do_cmp    = 1'b0;
    clr       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = S_ARMED;
        end else if (stop) begin
          state_nxt = S_DONE;
        end else if (vec_valid) begin
          ld_vec    = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = S_ARMED;
        end else if (stop) begin
          // pending comparison is dropped
          state_nxt = S_DONE;
        end else if (scnt == 4'd0) begin
          do_cmp = 1'b1;
          // a back-to-back vector chains straight into another settle
          if (vec_valid) ld_vec = 1'b1;
          else           state_nxt = S_ARMED;
        end else if (vec_valid) begin
          // newer vector replaces the pending one unscored
          ld_vec = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Vector latch and settle countdown
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec  <= 3'd0;
      scnt <= 4'd0;
    end else if (ld_vec) begin
      vec  <= {a, b, c};
      scnt <= 4'(SETTLE);
    end else if (state == S_SETTLE && scnt != 4'd0) begin
      scnt <= scnt - 4'd1;
    end

  // Result bookkeeping: counters saturate, err/first_fail capture the first miss
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mismatch   <= 1'b0;
      err        <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      coverage   <= 8'd0;
      first_fail <= 5'd0;
    end else begin
      mismatch <= 1'b0;
      if (clr) begin
        err        <= 1'b0;
        pass_cnt   <= '0;
        fail_cnt   <= '0;
        coverage   <= 8'd0;
        first_fail <= 5'd0;
      end else if (do_cmp) begin
        coverage[vec] <= 1'b1;
        if (cmp_ok) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          mismatch <= 1'b1;
          if (!err) begin
            err        <= 1'b1;
            first_fail <= {vec, sum, carry};
          end
        end
      end
    end

endmodule

// File: tb/tb_fulladder_checker.sv
// Bench for fulladder_checker: directed scenarios plus a random stream, scored
// against an arithmetic model ({carry,sum} must equal a+b+c).
module tb_fulladder_checker;
  localparam int SETTLE = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, stop = 0, vec_valid = 0, a = 0, b = 0, c = 0, sum = 0, carry = 0;

  logic        busy, done, mismatch, err, all_covered;
  logic [15:0] pass_cnt, fail_cnt;
  logic [7:0]  coverage;
  logic [4:0]  first_fail;

  logic        s_busy, s_done, s_mismatch, s_err, s_all;
  logic [2:0]  s_pass, s_fail;
  logic [7:0]  s_cov;
  logic [4:0]  s_ff;

  fulladder_checker #(.SETTLE(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
    .busy(busy), .done(done), .mismatch(mismatch), .err(err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .coverage(coverage),
    .all_covered(all_covered), .first_fail(first_fail));

  // narrow-counter twin sharing the same stimulus, for saturation
  fulladder_checker #(.SETTLE(SETTLE), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
    .busy(s_busy), .done(s_done), .mismatch(s_mismatch), .err(s_err),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .coverage(s_cov),
    .all_covered(s_all), .first_fail(s_ff));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  int         m_pass, m_fail;
  logic [7:0] m_cov;
  logic       m_err;
  logic [4:0] m_ff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic m_clear();
    m_pass = 0; m_fail = 0; m_cov = 8'd0; m_err = 1'b0; m_ff = 5'd0;
  endtask

  // score one vector against arithmetic truth; returns whether it failed
  task automatic m_upd(input logic va, vb, vc, s, cy, output logic bad);
    int t;
    logic [2:0] idx;
    t   = int'(va) + int'(vb) + int'(vc);
    idx = {va, vb, vc};
    m_cov[idx] = 1'b1;
    bad = ((int'(cy) * 2 + int'(s)) != t);
    if (!bad) m_pass++;
    else begin
      m_fail++;
      if (!m_err) begin m_err = 1'b1; m_ff = {va, vb, vc, s, cy}; end
    end
  endtask

  task automatic do_start();
    start = 1; step(); start = 0; m_clear();
  endtask

  task automatic do_stop();
    stop = 1; step(); stop = 0;
  endtask

  // Apply one vector; adder outputs carry garbage while settling and the real
  // (optionally corrupted) values only right before the compare edge.
  task automatic send(input logic va, vb, vc, fs, fc);
    int   t;
    logic s, cy, bad;
    t = int'(va) + int'(vb) + int'(vc);
    s  = logic'(t % 2) ^ fs;
    cy = logic'(t / 2) ^ fc;
    a = va; b = vb; c = vc; sum = ~s; carry = ~cy; vec_valid = 1;
    step(); vec_valid = 0;
    repeat (SETTLE) step();
    chk("early_mismatch", {31'd0, mismatch}, 32'd0);
    chk("early_pass", 32'(pass_cnt), 32'(m_pass));
    sum = s; carry = cy;
    step();
    m_upd(va, vb, vc, s, cy, bad);
    chk("mismatch", {31'd0, mismatch}, {31'd0, bad});
    chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_pass"}, 32'(pass_cnt), 32'(m_pass));
    chk({tag, "_fail"}, 32'(fail_cnt), 32'(m_fail));
    chk({tag, "_cov"}, 32'(coverage), 32'(m_cov));
    chk({tag, "_allcov"}, {31'd0, all_covered}, {31'd0, (m_cov == 8'hFF)});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, "_ff"}, 32'(first_fail), 32'(m_ff));
  endtask

  initial begin
    logic [2:0] v;
    int         f;
    m_clear();

    // reset, then vec_valid in IDLE must be ignored
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk_all("rst");
    rst_n = 1; step();
    a = 1; b = 1; c = 1; sum = 0; carry = 0; vec_valid = 1; step(); vec_valid = 0;
    repeat (5) step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_mismatch", {31'd0, mismatch}, 32'd0);
    chk_all("idle");

    // exhaustive pass with a correct adder
    do_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      send(v[2], v[1], v[0], 1'b0, 1'b0);
    end
    do_stop();
    chk("exh_done", {31'd0, done}, 32'd1);
    chk("exh_busy", {31'd0, busy}, 32'd0);
    chk_all("exh");

    // carry stuck low on the two carrying vectors
    do_start();
    chk_all("flt_clr");
    send(1, 1, 0, 1'b0, 1'b1);
    send(1, 1, 1, 1'b0, 1'b1);
    chk_all("flt");
    chk("flt_ff_lit", 32'(first_fail), 32'h18);

    // second vector during settle replaces the first
    do_start();
    a = 0; b = 1; c = 1; sum = 1; carry = 0; vec_valid = 1; step();
    a = 1; b = 0; c = 0; step(); vec_valid = 0;
    repeat (SETTLE + 1) step();
    m_upd(1, 0, 0, 1, 0, v[0]);
    chk_all("disc");
    chk("disc_cov_lit", 32'(coverage), 32'h10);

    // start+stop together while ARMED: restart wins
    do_start();
    send(0, 0, 1, 1'b0, 1'b0);
    start = 1; stop = 1; step(); start = 0; stop = 0; m_clear();
    chk("ss_busy", {31'd0, busy}, 32'd1);
    chk("ss_done", {31'd0, done}, 32'd0);
    chk_all("ss");

    // stop with a same-cycle vec_valid: vector not counted
    a = 1; b = 0; c = 1; sum = 0; carry = 1; vec_valid = 1; stop = 1;
    step(); vec_valid = 0; stop = 0;
    repeat (SETTLE + 2) step();
    chk("sv_done", {31'd0, done}, 32'd1);
    chk_all("sv");

    // stop while a comparison is pending drops it
    do_start();
    a = 1; b = 1; c = 0; sum = 0; carry = 1; vec_valid = 1; step(); vec_valid = 0;
    do_stop();
    repeat (SETTLE + 2) step();
    chk("sp_done", {31'd0, done}, 32'd1);
    chk_all("sp");

    // async reset mid-settle
    do_start();
    send(0, 1, 0, 1'b0, 1'b0);
    a = 1; b = 1; c = 1; sum = 1; carry = 1; vec_valid = 1; step(); vec_valid = 0;
    step();
    rst_n = 0; #1;
    m_clear();
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk_all("ar");
    step(); rst_n = 1; step();
    repeat (SETTLE + 1) step();
    chk("ar_idle_pass", 32'(pass_cnt), 32'd0);

    // saturation on the 3-bit twin
    do_start();
    for (int i = 0; i < 10; i++) begin
      v = i[2:0];
      send(v[2], v[1], v[0], 1'b0, 1'b0);
    end
    chk("sat_pass_wide", 32'(pass_cnt), 32'd10);
    chk("sat_pass_narrow", 32'(s_pass), 32'd7);

    // random stream with occasional corrupted outputs
    do_start();
    for (int i = 0; i < 48; i++) begin
      v = 3'($urandom_range(0, 7));
      f = int'($urandom_range(0, 5));
      send(v[2], v[1], v[0], f == 0, f == 1);
    end
    do_stop();
    chk("rnd_done", {31'd0, done}, 32'd1);
    chk_all("rnd");
    chk("rnd_sat_pass", 32'(s_pass), 32'((m_pass > 7) ? 7 : m_pass));
    chk("rnd_sat_fail", 32'(s_fail), 32'((m_fail > 7) ? 7 : m_fail));

    // results hold in DONE
    repeat (5) step();
    chk_all("hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
